// File: rtl/mem_port_arbiter.sv
// Arbiter and sequencer for the single shared memory port.
// Grants the port to fetch (port 0) or data (port 1), drives the steering mux
// select, times the fixed-latency access and pulses done for the owner.
// Ties alternate round-robin based on the owner of the last completed access.
module mem_port_arbiter #(
  parameter int unsigned LAT = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       sel_o,
  output logic       mem_start_o,
  output logic [1:0] done_o,
  output logic       busy_o,
  output logic [1:0] stall_o
);

  localparam int unsigned CntW = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(LAT - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            sel_q, sel_d;
  logic            mem_start_q, mem_start_d;
  logic [1:0]      done_q, done_d;
  logic            last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            win;

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      gnt_q       <= 2'b00;
      sel_q       <= 1'b0;
      mem_start_q <= 1'b0;
      done_q      <= 2'b00;
      last_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      mem_start_q <= mem_start_d;
      done_q      <= done_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
    end
  end

  // Arbitration in IDLE, latency countdown and completion in BUSY.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    mem_start_d = 1'b0;
    done_d      = 2'b00;
    last_d      = last_q;
    cnt_d       = cnt_q;
    win         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_i != 2'b00) begin
          // On a tie the port that did not complete last wins.
          win         = (req_i == 2'b11) ? ~last_q : req_i[1];
          state_d     = StBusy;
          gnt_d       = win ? 2'b10 : 2'b01;
          sel_d       = win;
          mem_start_d = 1'b1;
          cnt_d       = CntLoad;
        end
      end
      StBusy: begin
        // Requests are ignored here; the access always runs to completion.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = StIdle;
          gnt_d   = 2'b00;
          done_d  = gnt_q;
          last_d  = sel_q;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign gnt_o       = gnt_q;
  assign sel_o       = sel_q;
  assign mem_start_o = mem_start_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q == StBusy);
  // Owner's stall drops in its done cycle so the stage advances there.
  assign stall_o     = req_i & ~gnt_q & ~done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with LAT = 2.
module tb_mem_port_arbiter;

  logic       clk_i;
  logic       reset_i;
  logic [1:0] req_i;
  logic [1:0] gnt_o;
  logic       sel_o;
  logic       mem_start_o;
  logic [1:0] done_o;
  logic       busy_o;
  logic [1:0] stall_o;

  int errors;
  int checks;

  mem_port_arbiter #(
    .LAT(2)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .req_i      (req_i),
    .gnt_o      (gnt_o),
    .sel_o      (sel_o),
    .mem_start_o(mem_start_o),
    .done_o     (done_o),
    .busy_o     (busy_o),
    .stall_o    (stall_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    // Held in reset: every registered output at its reset value.
    reset_i = 1'b1;
    req_i   = 2'b11;
    tick();
    tick();
    checks++;
    if (gnt_o !== 2'b00 || sel_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 2'b00 ||
        mem_start_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold gnt=%b sel=%b busy=%b done=%b ms=%b, want 00 0 0 00 0",
               gnt_o, sel_o, busy_o, done_o, mem_start_o);
    end
    reset_i = 1'b0;
    req_i   = 2'b10;
    // Complete one data access so last becomes 1.
    tick();
    tick();
    tick();
    checks++;
    if (done_o !== 2'b10) begin
      errors++;
      $display("FAIL reset_pre_done done=%b want 10", done_o);
    end
    // Data re-requests (held), start another access and reset mid-BUSY.
    tick();
    checks++;
    if (gnt_o !== 2'b10 || sel_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_gnt gnt=%b sel=%b busy=%b want 10 1 1", gnt_o, sel_o, busy_o);
    end
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if (gnt_o !== 2'b00 || sel_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_async gnt=%b sel=%b busy=%b done=%b want 00 0 0 00",
               gnt_o, sel_o, busy_o, done_o);
    end
    tick();
    checks++;
    if (done_o !== 2'b00 || gnt_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_no_done done=%b gnt=%b want 00 00", done_o, gnt_o);
    end
    // Release with a tie: last was cleared, so data wins.
    reset_i = 1'b0;
    req_i   = 2'b11;
    tick();
    checks++;
    if (gnt_o !== 2'b10 || sel_o !== 1'b1 || mem_start_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_tie gnt=%b sel=%b ms=%b want 10 1 1", gnt_o, sel_o, mem_start_o);
    end
    tick();
    tick();
    req_i = 2'b01;
    tick();
    checks++;
    if (gnt_o !== 2'b01 || sel_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_then_fetch gnt=%b sel=%b want 01 0", gnt_o, sel_o);
    end
    tick();
    tick();
    req_i = 2'b00;
    tick();
  endtask

  task automatic test_single_fetch();
    req_i = 2'b01;
    #1;
    checks++;
    if (stall_o !== 2'b01) begin
      errors++;
      $display("FAIL fetch_c0_stall stall=%b want 01", stall_o);
    end
    tick();
    checks++;
    if (gnt_o !== 2'b01 || mem_start_o !== 1'b1 || busy_o !== 1'b1 || sel_o !== 1'b0 ||
        stall_o !== 2'b00) begin
      errors++;
      $display("FAIL fetch_c1 gnt=%b ms=%b busy=%b sel=%b stall=%b want 01 1 1 0 00",
               gnt_o, mem_start_o, busy_o, sel_o, stall_o);
    end
    tick();
    checks++;
    if (gnt_o !== 2'b01 || mem_start_o !== 1'b0 || done_o !== 2'b00 || stall_o !== 2'b00) begin
      errors++;
      $display("FAIL fetch_c2 gnt=%b ms=%b done=%b stall=%b want 01 0 00 00",
               gnt_o, mem_start_o, done_o, stall_o);
    end
    tick();
    checks++;
    if (done_o !== 2'b01 || gnt_o !== 2'b00 || busy_o !== 1'b0 || stall_o !== 2'b00) begin
      errors++;
      $display("FAIL fetch_c3 done=%b gnt=%b busy=%b stall=%b want 01 00 0 00",
               done_o, gnt_o, busy_o, stall_o);
    end
    req_i = 2'b00;
    tick();
    checks++;
    if (done_o !== 2'b00 || gnt_o !== 2'b00 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL fetch_c4 done=%b gnt=%b busy=%b want 00 00 0", done_o, gnt_o, busy_o);
    end
  endtask

  task automatic test_contention();
    logic       p;
    logic [1:0] exp_g;
    req_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      p     = (i % 2 == 0) ? 1'b1 : 1'b0;
      exp_g = p ? 2'b10 : 2'b01;
      tick();
      checks++;
      if (gnt_o !== exp_g || sel_o !== p || mem_start_o !== 1'b1) begin
        errors++;
        $display("FAIL cont_grant%0d gnt=%b sel=%b ms=%b want %b %b 1",
                 i, gnt_o, sel_o, mem_start_o, exp_g, p);
      end
      req_i = 2'b11;
      #1;
      checks++;
      if (stall_o !== ~exp_g) begin
        errors++;
        $display("FAIL cont_stall%0d stall=%b want %b", i, stall_o, ~exp_g);
      end
      tick();
      checks++;
      if (gnt_o !== exp_g || sel_o !== p) begin
        errors++;
        $display("FAIL cont_hold%0d gnt=%b sel=%b want %b %b", i, gnt_o, sel_o, exp_g, p);
      end
      tick();
      checks++;
      if (done_o !== exp_g || gnt_o !== 2'b00 || sel_o !== p) begin
        errors++;
        $display("FAIL cont_done%0d done=%b gnt=%b sel=%b want %b 00 %b",
                 i, done_o, gnt_o, sel_o, exp_g, p);
      end
      req_i = (i == 3) ? 2'b00 : ~exp_g;
    end
    tick();
    checks++;
    if (gnt_o !== 2'b00 || sel_o !== 1'b0) begin
      errors++;
      $display("FAIL cont_idle gnt=%b sel=%b want 00 0", gnt_o, sel_o);
    end
  endtask

  task automatic test_starvation();
    req_i = 2'b10;
    tick();
    checks++;
    if (gnt_o !== 2'b10) begin
      errors++;
      $display("FAIL starve_data gnt=%b want 10", gnt_o);
    end
    req_i = 2'b11;
    #1;
    checks++;
    if (stall_o !== 2'b01) begin
      errors++;
      $display("FAIL starve_stall1 stall=%b want 01", stall_o);
    end
    tick();
    tick();
    checks++;
    if (done_o !== 2'b10 || stall_o !== 2'b01) begin
      errors++;
      $display("FAIL starve_done done=%b stall=%b want 10 01", done_o, stall_o);
    end
    tick();
    checks++;
    if (gnt_o !== 2'b01 || sel_o !== 1'b0 || stall_o !== 2'b10) begin
      errors++;
      $display("FAIL starve_fetch gnt=%b sel=%b stall=%b want 01 0 10", gnt_o, sel_o, stall_o);
    end
    tick();
    tick();
    checks++;
    if (done_o !== 2'b01) begin
      errors++;
      $display("FAIL starve_fdone done=%b want 01", done_o);
    end
    req_i = 2'b10;
    tick();
    checks++;
    if (gnt_o !== 2'b10 || sel_o !== 1'b1) begin
      errors++;
      $display("FAIL starve_data2 gnt=%b sel=%b want 10 1", gnt_o, sel_o);
    end
    tick();
    tick();
    req_i = 2'b00;
    tick();
  endtask

  task automatic test_owner_drop();
    req_i = 2'b10;
    tick();
    checks++;
    if (gnt_o !== 2'b10 || mem_start_o !== 1'b1) begin
      errors++;
      $display("FAIL drop_c1 gnt=%b ms=%b want 10 1", gnt_o, mem_start_o);
    end
    tick();
    req_i = 2'b00;
    #1;
    checks++;
    if (gnt_o !== 2'b10 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL drop_c2 gnt=%b busy=%b want 10 1", gnt_o, busy_o);
    end
    tick();
    checks++;
    if (done_o !== 2'b10 || gnt_o !== 2'b00) begin
      errors++;
      $display("FAIL drop_c3 done=%b gnt=%b want 10 00", done_o, gnt_o);
    end
    tick();
    checks++;
    if (gnt_o !== 2'b00 || done_o !== 2'b00 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL drop_c4 gnt=%b done=%b busy=%b want 00 00 0", gnt_o, done_o, busy_o);
    end
  endtask

  task automatic test_back_to_back();
    req_i = 2'b01;
    tick();
    tick();
    tick();
    checks++;
    if (done_o !== 2'b01 || gnt_o !== 2'b00) begin
      errors++;
      $display("FAIL b2b_done1 done=%b gnt=%b want 01 00", done_o, gnt_o);
    end
    tick();
    checks++;
    if (gnt_o !== 2'b01 || mem_start_o !== 1'b1 || done_o !== 2'b00) begin
      errors++;
      $display("FAIL b2b_regrant gnt=%b ms=%b done=%b want 01 1 00", gnt_o, mem_start_o, done_o);
    end
    tick();
    tick();
    checks++;
    if (done_o !== 2'b01 || gnt_o !== 2'b00) begin
      errors++;
      $display("FAIL b2b_done2 done=%b gnt=%b want 01 00", done_o, gnt_o);
    end
    req_i = 2'b00;
    tick();
    checks++;
    if (gnt_o !== 2'b00 || mem_start_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle gnt=%b ms=%b want 00 0", gnt_o, mem_start_o);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset_i = 1'b1;
    req_i   = 2'b00;
    test_reset();
    test_single_fetch();
    test_contention();
    test_starvation();
    test_owner_drop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
